// File: rtl/uart_tx_dma_controller.sv
// Memory-to-UART DMA engine: on a start edge, reads transfer_size bytes from
// memory beginning at start_address and sends each byte as an 8N1 frame on tx.
module uart_tx_dma_controller #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int SIZE_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_address,
    input  logic [SIZE_WIDTH-1:0] transfer_size,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    output logic                  mem_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done,
    output logic [SIZE_WIDTH-1:0] bytes_sent
);
    localparam int FRAME_BITS = DATA_WIDTH + 2;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BAUD_W-1:0] LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);

    // Handshakes: start is edge-triggered and honoured only in IDLE; done is a level
    // that holds until start is seen low in IDLE. mem_read_enable is a one-cycle strobe
    // and the memory returns mem_read_data on the following cycle, captured in LOAD.
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_SEND, S_DONE} state_t;

    state_t                  state, state_n;
    logic                    start_prev, start_edge;
    logic [SIZE_WIDTH-1:0]   size_q, size_n, sent_n, sent_inc;
    logic [ADDR_WIDTH-1:0]   addr_n;
    logic                    ren_n, tx_n, busy_n, done_n;
    logic [DATA_WIDTH:0]     shift_q, shift_n;
    logic [BIT_W-1:0]        bit_cnt, bit_n;
    logic [BAUD_W-1:0]       baud_cnt, baud_n;

    assign start_edge = start && !start_prev;
    assign sent_inc   = bytes_sent + SIZE_WIDTH'(1);

    always_comb begin
        state_n = state;
        size_n  = size_q;
        sent_n  = bytes_sent;
        addr_n  = mem_read_address;
        ren_n   = 1'b0;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = done;
        shift_n = shift_q;
        bit_n   = bit_cnt;
        baud_n  = baud_cnt;
        case (state)
            S_IDLE: begin
                tx_n = 1'b1;
                if (start_edge) begin
                    done_n = 1'b0;
                    sent_n = '0;
                    if (transfer_size != '0) begin
                        size_n  = transfer_size;
                        addr_n  = start_address;
                        ren_n   = 1'b1;
                        busy_n  = 1'b1;
                        state_n = S_REQ;
                    end else begin
                        state_n = S_DONE;
                    end
                end else if (!start) begin
                    done_n = 1'b0;
                end
            end
            S_REQ: state_n = S_LOAD;
            S_LOAD: begin
                // The shift register carries the stop bit above the data byte.
                shift_n = {1'b1, mem_read_data};
                tx_n    = 1'b0;
                bit_n   = '0;
                baud_n  = '0;
                state_n = S_SEND;
            end
            S_SEND: begin
                if (baud_cnt == LAST_TICK) begin
                    baud_n = '0;
                    if (bit_cnt == LAST_BIT) begin
                        sent_n = sent_inc;
                        addr_n = mem_read_address + ADDR_WIDTH'(1);
                        if (sent_inc == size_q) begin
                            state_n = S_DONE;
                        end else begin
                            ren_n   = 1'b1;
                            state_n = S_REQ;
                        end
                    end else begin
                        bit_n   = bit_cnt + BIT_W'(1);
                        tx_n    = shift_q[0];
                        shift_n = {1'b1, shift_q[DATA_WIDTH:1]};
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= S_IDLE;
            start_prev       <= 1'b0;
            size_q           <= '0;
            bytes_sent       <= '0;
            mem_read_address <= '0;
            mem_read_enable  <= 1'b0;
            tx               <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b0;
            shift_q          <= '1;
            bit_cnt          <= '0;
            baud_cnt         <= '0;
        end else begin
            state            <= state_n;
            start_prev       <= start;
            size_q           <= size_n;
            bytes_sent       <= sent_n;
            mem_read_address <= addr_n;
            mem_read_enable  <= ren_n;
            tx               <= tx_n;
            busy             <= busy_n;
            done             <= done_n;
            shift_q          <= shift_n;
            bit_cnt          <= bit_n;
            baud_cnt         <= baud_n;
        end
    end
endmodule

// File: tb/tb_uart_tx_dma_controller.sv
// Bench for uart_tx_dma_controller: per-cycle schedule model, UART frame decoder
// with expected-byte queue, directed scenarios and a randomized start waveform.
module tb_uart_tx_dma_controller;
    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int SW  = 8;
    localparam int CPB = 4;
    localparam int F   = (DW + 2) * CPB;
    localparam int P   = F + 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_address = '0;
    logic [SW-1:0] transfer_size = '0;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_enable;
    logic [DW-1:0] mem_read_data = '0;
    logic          tx, busy, done;
    logic [SW-1:0] bytes_sent;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    uart_tx_dma_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start),
        .start_address(start_address), .transfer_size(transfer_size),
        .mem_read_address(mem_read_address), .mem_read_enable(mem_read_enable),
        .mem_read_data(mem_read_data), .tx(tx), .busy(busy), .done(done),
        .bytes_sent(bytes_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic frame_bit(input logic [DW-1:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j > DW) return 1'b1;
        return b[j-1];
    endfunction

    // Memory with one-cycle read latency; every strobed address is logged.
    logic [DW-1:0] mem [0:255];
    logic [AW-1:0] rd_log[$];
    always @(posedge clk) begin
        if (mem_read_enable) begin
            mem_read_data <= mem[mem_read_address];
            rd_log.push_back(mem_read_address);
        end
    end

    // Reference model: outputs derived from the accept edge E by frame arithmetic.
    logic          m_prev, m_xfer, m_tx, m_ren, m_busy, m_done;
    logic [AW-1:0] m_a, m_addr;
    logic [SW-1:0] m_sent;
    int            m_e, m_n, m_idle_from, m_done_edge;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        int  rel, k, off;
        bit  acc, idle_now;
        cyc = cyc + 1;
        if (!rstn) begin
            m_prev = 1'b0; m_xfer = 1'b0; m_tx = 1'b1; m_ren = 1'b0; m_busy = 1'b0;
            m_done = 1'b0; m_addr = '0; m_sent = '0; m_a = '0; m_e = 0; m_n = 0;
            m_idle_from = cyc; m_done_edge = -1;
            exp_q.delete();
        end else begin
            idle_now = (cyc >= m_idle_from);
            acc      = idle_now && start && !m_prev;
            m_prev   = start;
            if (acc) begin
                m_done = 1'b0;
                m_sent = '0;
                if (transfer_size != '0) begin
                    m_xfer = 1'b1; m_e = cyc; m_n = int'(transfer_size); m_a = start_address;
                    m_done_edge = cyc + m_n * P + 1;
                    m_idle_from = cyc + m_n * P + 2;
                    for (int i = 0; i < m_n; i++) exp_q.push_back(mem[m_a + AW'(i)]);
                end else begin
                    m_xfer = 1'b0; m_done_edge = cyc + 1; m_idle_from = cyc + 2;
                end
            end else if (cyc == m_done_edge) begin
                m_done = 1'b1;
            end else if (idle_now && !start) begin
                m_done = 1'b0;
            end
            if (m_xfer) begin
                rel    = cyc - m_e;
                m_busy = (cyc <= m_e + m_n * P);
                m_ren  = ((rel % P) == 0) && ((rel / P) < m_n);
                m_addr = m_a + AW'(imin(rel / P, m_n));
                m_sent = SW'(imin(rel / P, m_n));
                m_tx   = 1'b1;
                if (rel >= 2) begin
                    k   = (rel - 2) / P;
                    off = (rel - 2) % P;
                    if (k < m_n && off < F) m_tx = frame_bit(mem[m_a + AW'(k)], off / CPB);
                end
            end else begin
                m_busy = 1'b0; m_ren = 1'b0; m_tx = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("tx", 32'(tx), 32'(m_tx));
            chk("mem_read_enable", 32'(mem_read_enable), 32'(m_ren));
            chk("mem_read_address", 32'(mem_read_address), 32'(m_addr));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("bytes_sent", 32'(bytes_sent), 32'(m_sent));
        end
    end

    // UART decoder: samples mid-bit, scoreboards each byte against exp_q.
    bit            mon_act = 1'b0;
    int            mon_cnt = 0;
    logic [DW-1:0] mon_byte;
    logic [DW-1:0] rx_log[$];
    int            frame_cyc[$];
    always @(negedge clk) begin
        if (!rstn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx == 1'b0) begin
                mon_act = 1'b1; mon_cnt = 0; frame_cyc.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB) == CPB / 2) begin
                if (mon_cnt / CPB <= DW) begin
                    mon_byte[mon_cnt / CPB - 1] = tx;
                end else begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    rx_log.push_back(mon_byte);
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL uart_byte: got %0h, required none (cycle %0d)", mon_byte, cyc);
                    end else begin
                        chk("uart_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        bit got;
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("done_within_bound", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [AW-1:0] a, input logic [SW-1:0] n, input int width);
        start_address = a; transfer_size = n; start = 1'b1;
        tick(width);
        start = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] lit1 [3];
        logic [DW-1:0] lit3 [3];
        logic [AW-1:0] lita [3];
        bit found;
        int e_cyc;
        lit1 = '{8'h41, 8'h64, 8'h76};
        lit3 = '{8'hAA, 8'h55, 8'hC3};
        lita = '{8'hFE, 8'hFF, 8'h00};
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        fork
            begin
                #5_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ren", 32'(mem_read_enable), 32'd0);
        chk("reset_addr", 32'(mem_read_address), 32'd0);
        chk("reset_sent", 32'(bytes_sent), 32'd0);
        rstn = 1'b1;
        tick(2);

        // Three bytes from 0x10, with start-to-first-start-bit latency.
        mem[8'h10] = 8'h41; mem[8'h11] = 8'h64; mem[8'h12] = 8'h76;
        rx_log.delete(); rd_log.delete();
        e_cyc = cyc + 1;
        go(8'h10, 8'd3, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (tx == 1'b0) found = 1'b1;
        end
        if (found) chk("tx_fall_latency", 32'(cyc - e_cyc), 32'd2);
        else chk("tx_fall_seen", 32'(found), 32'd1);
        wait_done(4 * P);
        chk("t1_bytes_sent", 32'(bytes_sent), 32'd3);
        chk("t1_rx_count", 32'(rx_log.size()), 32'd3);
        for (int i = 0; i < rx_log.size() && i < 3; i++) chk("t1_rx_byte", 32'(rx_log[i]), 32'(lit1[i]));

        // Zero-length transfer.
        rd_log.delete();
        tick(2);
        go(8'h33, 8'd0, 1);
        @(negedge clk);
        chk("size0_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("size0_done", 32'(done), 32'd1);
        chk("size0_busy", 32'(busy), 32'd0);
        tick(4);
        chk("size0_reads", 32'(rd_log.size()), 32'd0);
        chk("size0_done_clear", 32'(done), 32'd0);

        // Address wrap across 0xFF.
        mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'h55; mem[8'h00] = 8'hC3;
        rx_log.delete(); rd_log.delete();
        go(8'hFE, 8'd3, 2);
        wait_done(4 * P);
        chk("wrap_reads", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < rd_log.size() && i < 3; i++) chk("wrap_addr", 32'(rd_log[i]), 32'(lita[i]));
        chk("wrap_rx_count", 32'(rx_log.size()), 32'd3);
        for (int i = 0; i < rx_log.size() && i < 3; i++) chk("wrap_rx_byte", 32'(rx_log[i]), 32'(lit3[i]));

        // Reset in the middle of the second byte's data bits, then restart.
        rx_log.delete();
        go(8'h10, 8'd3, 1);
        tick(1 + P + 3 * CPB);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sent", 32'(bytes_sent), 32'd0);
        chk("rst_partial_rx", 32'(rx_log.size()), 32'd1);
        tick(3);
        rstn = 1'b1;
        rx_log.delete();
        tick(2);
        go(8'h10, 8'd3, 1);
        wait_done(4 * P);
        chk("restart_rx_count", 32'(rx_log.size()), 32'd3);
        if (rx_log.size() > 0) chk("restart_first_byte", 32'(rx_log[0]), 32'h41);

        // Re-pulses while busy, then start held through done.
        rx_log.delete(); rd_log.delete(); frame_cyc.delete();
        tick(2);
        start_address = 8'h20; transfer_size = 8'd2; start = 1'b1;
        tick(3);  start = 1'b0;
        tick(5);  start = 1'b1;
        tick(2);  start = 1'b0;
        tick(30); start = 1'b1;
        wait_done(3 * P);
        tick(10);
        chk("held_done", 32'(done), 32'd1);
        chk("held_busy", 32'(busy), 32'd0);
        chk("held_reads", 32'(rd_log.size()), 32'd2);
        chk("held_rx_count", 32'(rx_log.size()), 32'd2);
        if (frame_cyc.size() >= 2) chk("frame_gap", 32'(frame_cyc[1] - frame_cyc[0] - F), 32'd2);
        else chk("frame_gap_count", 32'(frame_cyc.size()), 32'd2);
        start = 1'b0;
        tick(1);
        chk("done_release", 32'(done), 32'd0);

        // Randomized start waveform; inputs change freely while busy.
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int it = 0; it < 15; it++) begin
            start_address = 8'($urandom_range(0, 255));
            transfer_size = 8'($urandom_range(0, 4));
            start = 1'b1;
            tick($urandom_range(1, 3));
            start = 1'b0;
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 15) == 0) start = ~start;
                start_address = 8'($urandom_range(0, 255));
                transfer_size = 8'($urandom_range(0, 4));
                tick(1);
            end
        end
        start = 1'b0;
        tick(5 * P);
        chk("random_drain", 32'(exp_q.size()), 32'd0);

        // Largest legal transfer.
        rx_log.delete();
        go(8'h80, 8'd255, 1);
        wait_done(256 * P);
        chk("max_bytes_sent", 32'(bytes_sent), 32'd255);
        chk("max_rx_count", 32'(rx_log.size()), 32'd255);
        tick(2);
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
